seg_display_scanner: RTL and testbench

Time-multiplexed driver for a common-anode multi-digit 7-segment display. Latches a packed hex value and walks one digit per refresh slot. For each slot it presents that digit's nibble to the downstream hex-to-7-segment decoder and drives the matching active-low anode. Optional leading-zero blanking; one-cycle frame tick for ALU-tester sequencing logic.

---
 rtl/seg_display_scanner.sv | 95 +++++++++
 tb/tb_seg_display_scanner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - time-multiplexed common-anode 7-segment digit scanner
//
// Latches a packed hex value into a shadow register and presents one digit
// per refresh slot: that digit's nibble on hex for the downstream decoder,
// and its active-low anode.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   enable     1 = scan running, 0 = display dark with scan frozen
//   load       capture value into the shadow register on this edge
//   value      packed hex digits, [3:0] is digit 0 (rightmost)
//   blank_lz   blank leading zero digits (digit 0 always shown)
//   hex        nibble of the current digit
//   anode_n    active-low digit enables, one low bit or all ones
//   frame_tick one-cycle pulse at the end of each full scan
module seg_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [CW-1:0]           cnt;
  logic [DW-1:0]           dig;

  logic                    slot_end;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic                    cur_blank;

  assign slot_end = (cnt == CNT_LAST);

  // Digit selection from the current shadow/dig. A digit is a leading zero
  // when the shadow shifted down to that digit is entirely zero; digit 0 is
  // exempt so a value of zero still shows a single "0".
  always_comb begin
    cur_nib   = 4'd0;
    sel_n     = '1;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig == DW'(i)) begin
        cur_nib   = shadow[4*i +: 4];
        sel_n[i]  = 1'b0;
        cur_blank = blank_lz && (i != 0) && ((shadow >> (4*i)) == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      cnt        <= '0;
      dig        <= '0;
      hex        <= 4'd0;
      anode_n    <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
      end

      if (enable) begin
        if (slot_end) begin
          cnt <= '0;
          dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // Outputs follow shadow/dig with one cycle of latency, so a load shows
      // up mid-slot rather than waiting for the next digit boundary. hex keeps
      // tracking even when the digit is dark.
      hex        <= cur_nib;
      anode_n    <= (enable && !cur_blank) ? sel_n : '1;
      frame_tick <= enable && slot_end && (dig == DIG_LAST);
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - self-checking bench for seg_display_scanner
module tb_seg_display_scanner;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          load;
  logic [15:0]   value;
  logic          blank_lz;
  logic [3:0]    hex;
  logic [ND-1:0] anode_n;
  logic          frame_tick;

  int total = 0;
  int bad   = 0;

  // Reference model: the scan position is a single phase 0..FRAME-1, the
  // digit being phase / RD; the shadow value is plain integer data.
  logic [31:0] m_shadow;
  int          m_phase;
  logic [31:0] exp_hex, exp_an, exp_ft;
  int          tick_cnt;
  logic        prev_ft;

  always #5 clk = ~clk;

  seg_display_scanner #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .value     (value),
    .blank_lz  (blank_lz),
    .hex       (hex),
    .anode_n   (anode_n),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [15:0] val,
                      input logic en, input logic bl);
    int          d;
    logic [31:0] above;
    reset    = rst;
    load     = ld;
    value    = val;
    enable   = en;
    blank_lz = bl;
    d     = m_phase / RD;
    above = m_shadow >> (4 * d);
    exp_hex = above & 32'hF;
    exp_an  = (en && !(bl && d != 0 && above == 0)) ? (~(32'd1 << d)) & 32'hF : 32'hF;
    exp_ft  = (en && m_phase == FRAME - 1) ? 32'd1 : 32'd0;
    if (rst) begin
      m_shadow = 0;
      m_phase  = 0;
      exp_hex  = 0;
      exp_an   = 32'hF;
      exp_ft   = 0;
    end else begin
      if (ld) m_shadow = {16'd0, val};
      if (en) m_phase = (m_phase + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    check("hex", {28'd0, hex}, exp_hex);
    check("anode_n", {28'd0, anode_n}, exp_an);
    check("frame_tick", {31'd0, frame_tick}, exp_ft);
    check("anode_one_low", ($countones(~anode_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
    check("tick_not_consecutive", {31'd0, frame_tick & prev_ft}, 32'd0);
    if (frame_tick) tick_cnt++;
    prev_ft = frame_tick;
  endtask

  initial begin
    logic [15:0] rv;
    int          guard;
    m_shadow = 0;
    m_phase  = 0;
    tick_cnt = 0;
    prev_ft  = 1'b0;
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    enable   = 1'b0;
    blank_lz = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    check("reset_anode", {28'd0, anode_n}, 32'hF);
    check("reset_hex", {28'd0, hex}, 32'h0);

    // Load 1234 with scan frozen, then run: digit 0 first
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("first_digit_hex", {28'd0, hex}, 32'h4);
    check("first_digit_anode", {28'd0, anode_n}, 32'hE);
    for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Three full frames: exactly three ticks
    tick_cnt = 0;
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("ticks_in_3_frames", tick_cnt, 3);

    // Leading-zero blanking
    step(1'b0, 1'b1, 16'h0050, 1'b1, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Load mid-slot of digit 2 (phase 2*RD+1)
    step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    guard = 0;
    while (m_phase != 2 * RD + 1 && guard < 2 * FRAME) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      guard++;
    end
    check("reach_digit2_midslot", (m_phase == 2 * RD + 1) ? 32'd1 : 32'd0, 32'd1);
    step(1'b0, 1'b1, 16'hABCD, 1'b1, 1'b0);
    check("load_edge_old_hex", {28'd0, hex}, 32'h2);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("load_midslot_hex", {28'd0, hex}, 32'hB);
    check("load_midslot_anode", {28'd0, anode_n}, 32'hB);

    // Freeze for 10 cycles mid-slot, then resume
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Reset with load during digit 3
    guard = 0;
    while (m_phase != 3 * RD + 1 && guard < 2 * FRAME) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b1, 1'b1, 16'h5678, 1'b1, 1'b0);
    check("midreset_anode", {28'd0, anode_n}, 32'hF);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check("after_reset_hex", {28'd0, hex}, 32'h0);
    check("after_reset_anode", {28'd0, anode_n}, 32'hE);
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 5) == 0),
           rv,
           ($urandom_range(0, 7) != 0),
           1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
